// File: rtl/cordic_pipeline_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cordic_pipeline_param
//  Description : Fully pipelined CORDIC engine, per-sample rotation/vectoring
//                mode, 90-degree pre-rotation and valid/ready backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_pipeline_param #(
    parameter int WIDTH     = 16,
    parameter int ANG_WIDTH = 16,
    parameter int STAGES    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic signed [WIDTH-1:0]     x_in,
    input  logic signed [WIDTH-1:0]     y_in,
    input  logic signed [ANG_WIDTH-1:0] z_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_mode,
    output logic signed [WIDTH+1:0]     x_out,
    output logic signed [WIDTH+1:0]     y_out,
    output logic signed [ANG_WIDTH-1:0] z_out
);

    localparam int c_XW = WIDTH + 2;
    localparam logic [ANG_WIDTH-1:0] c_Q90 = {2'b01, {(ANG_WIDTH-2){1'b0}}};

    // atan(2^-i) / (2*pi) * 2^32
    function automatic logic [31:0] atan_raw(input int i);
        logic [31:0] t;
        case (i)
            0:  t = 32'h2000_0000;
            1:  t = 32'h12E4_051E;
            2:  t = 32'h09FB_385B;
            3:  t = 32'h0511_11D4;
            4:  t = 32'h028B_0D43;
            5:  t = 32'h0145_D7E1;
            6:  t = 32'h00A2_F61E;
            7:  t = 32'h0051_7C55;
            8:  t = 32'h0028_BE53;
            9:  t = 32'h0014_5F2F;
            10: t = 32'h000A_2F98;
            11: t = 32'h0005_17CC;
            12: t = 32'h0002_8BE6;
            13: t = 32'h0001_45F3;
            14: t = 32'h0000_A2FA;
            15: t = 32'h0000_517D;
            16: t = 32'h0000_28BE;
            17: t = 32'h0000_145F;
            18: t = 32'h0000_0A30;
            19: t = 32'h0000_0518;
            20: t = 32'h0000_028C;
            21: t = 32'h0000_0146;
            22: t = 32'h0000_00A3;
            23: t = 32'h0000_0051;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

    // Scale to ANG_WIDTH bits: (t * 2^ANG_WIDTH + 2^31) >> 32 gives round-half-up.
    function automatic logic [ANG_WIDTH-1:0] atan_ang(input int i);
        logic [63:0] r;
        r = {32'd0, atan_raw(i)} << ANG_WIDTH;
        r = r + 64'h0000_0000_8000_0000;
        return r[32 +: ANG_WIDTH];
    endfunction

    logic signed [c_XW-1:0]      x_q [STAGES+1];
    logic signed [c_XW-1:0]      y_q [STAGES+1];
    logic signed [ANG_WIDTH-1:0] z_q [STAGES+1];
    logic signed [c_XW-1:0]      x_d [STAGES+1];
    logic signed [c_XW-1:0]      y_d [STAGES+1];
    logic signed [ANG_WIDTH-1:0] z_d [STAGES+1];
    logic [STAGES:0]             v_q, v_d, m_q, m_d;

    logic signed [c_XW-1:0]      xs, ys;
    logic                        advance;

    assign xs       = {{2{x_in[WIDTH-1]}}, x_in};
    assign ys       = {{2{y_in[WIDTH-1]}}, y_in};
    assign advance  = !v_q[STAGES] || out_ready;
    assign in_ready = advance;

    always_comb begin
        x_d[0] = xs;
        y_d[0] = ys;
        z_d[0] = z_in;
        v_d    = {v_q[STAGES-1:0], in_valid};
        m_d    = {m_q[STAGES-1:0], in_mode};

        // Fold the input into the +-90 degree convergence range of the stages.
        if (!in_mode) begin
            if (z_in[ANG_WIDTH-1:ANG_WIDTH-2] == 2'b01) begin
                x_d[0] = -ys;
                y_d[0] = xs;
                z_d[0] = z_in - c_Q90;
            end else if (z_in[ANG_WIDTH-1:ANG_WIDTH-2] == 2'b10) begin
                x_d[0] = ys;
                y_d[0] = -xs;
                z_d[0] = z_in + c_Q90;
            end
        end else if (xs[c_XW-1]) begin
            if (!ys[c_XW-1]) begin
                x_d[0] = ys;
                y_d[0] = -xs;
                z_d[0] = z_in + c_Q90;
            end else begin
                x_d[0] = -ys;
                y_d[0] = xs;
                z_d[0] = z_in - c_Q90;
            end
        end

        for (int i = 0; i < STAGES; i++) begin
            if (m_q[i] ? y_q[i][c_XW-1] : !z_q[i][ANG_WIDTH-1]) begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
                z_d[i+1] = z_q[i] - atan_ang(i);
            end else begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
                z_d[i+1] = z_q[i] + atan_ang(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= STAGES; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                z_q[k] <= '0;
            end
            v_q <= '0;
            m_q <= '0;
        end else if (advance) begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            v_q <= v_d;
            m_q <= m_d;
        end
    end

    assign out_valid = v_q[STAGES];
    assign out_mode  = m_q[STAGES];
    assign x_out     = x_q[STAGES];
    assign y_out     = y_q[STAGES];
    assign z_out     = z_q[STAGES];

endmodule
`default_nettype wire
